// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings and opcode constants for the multi-cycle LEGv8 sequencer
//
// Holds the state encoding, the instruction class encoding, the opcode
// constants and masks, the ALUOp values, and a masked-opcode match helper.
package mc_ctrl_pkg;

    localparam int MC_OPC_W = 11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } mc_state_e;

    // CLS_NONE is only the cleared value of the class register; the decoder
    // never produces it.
    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_LD   = 3'd2,
        CLS_ST   = 3'd3,
        CLS_CBZ  = 3'd4,
        CLS_B    = 3'd5,
        CLS_ILL  = 3'd6
    } mc_class_e;

    localparam logic [MC_OPC_W-1:0] OPC_ADD      = 11'b10001011000;
    localparam logic [MC_OPC_W-1:0] OPC_SUB      = 11'b11001011000;
    localparam logic [MC_OPC_W-1:0] OPC_AND      = 11'b10001010000;
    localparam logic [MC_OPC_W-1:0] OPC_ORR      = 11'b10101010000;
    localparam logic [MC_OPC_W-1:0] OPC_LDUR     = 11'b11111000010;
    localparam logic [MC_OPC_W-1:0] OPC_STUR     = 11'b11111000000;
    localparam logic [MC_OPC_W-1:0] OPC_CBZ_VAL  = 11'b10110100000;
    localparam logic [MC_OPC_W-1:0] OPC_CBZ_MASK = 11'b11111111000;
    localparam logic [MC_OPC_W-1:0] OPC_B_VAL    = 11'b00010100000;
    localparam logic [MC_OPC_W-1:0] OPC_B_MASK   = 11'b11111100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    function automatic logic opc_match(input logic [MC_OPC_W-1:0] opc,
                                       input logic [MC_OPC_W-1:0] val,
                                       input logic [MC_OPC_W-1:0] mask);
        return (opc & mask) == (val & mask);
    endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// rtl/mc_opcode_decode.sv - combinational opcode to instruction-class mapper
//
// Ports:
//   opcode   in   instruction bits [31:21]
//   op_class out  decoded class (R, LD, ST, CBZ, B or ILL)
module mc_opcode_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W = 11
) (
    input  logic [OPC_W-1:0] opcode,
    output mc_class_e        op_class
);

    always_comb begin
        op_class = CLS_ILL;
        if (opcode == OPC_ADD || opcode == OPC_SUB ||
            opcode == OPC_AND || opcode == OPC_ORR) begin
            op_class = CLS_R;
        end else if (opcode == OPC_LDUR) begin
            op_class = CLS_LD;
        end else if (opcode == OPC_STUR) begin
            op_class = CLS_ST;
        end else if (opc_match(opcode, OPC_CBZ_VAL, OPC_CBZ_MASK)) begin
            op_class = CLS_CBZ;
        end else if (opc_match(opcode, OPC_B_VAL, OPC_B_MASK)) begin
            op_class = CLS_B;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the LEGv8 datapath
//
// Optional performance counters are built when MC_CTRL_PERF_CNT_EN is defined;
// otherwise cycle_cnt and instr_cnt are tied to 0.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   opcode                instruction bits [31:21] from the IR
//   zero                  ALU zero flag (CBZ outcome)
//   imem_ready/dmem_ready memory handshake completions
//   imem_req, ir_write    fetch request and IR load
//   pc_write, pc_src      PC update and source select
//   reg2loc, alu_src, mem_to_reg, alu_op   datapath selects
//   reg_write, mem_read, mem_write         datapath enables
//   state, illegal, retired                debug state, trap, retire pulse
//   cycle_cnt, instr_cnt                   performance counters
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W = 11,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg2loc,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             retired,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    mc_state_e state_q, state_d;
    mc_class_e class_q, class_d;
    mc_class_e dec_class;
    mc_class_e sel_class;

    logic       imem_req_raw, ir_write_raw, pc_write_raw, pc_src_raw;
    logic       reg2loc_raw, alu_src_raw, mem_to_reg_raw, reg_write_raw;
    logic       mem_read_raw, mem_write_raw, illegal_raw;
    logic [1:0] alu_op_raw;

    mc_opcode_decode #(
        .OPC_W(OPC_W)
    ) u_decode (
        .opcode  (opcode),
        .op_class(dec_class)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            class_q <= CLS_NONE;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    // Next state and enables.
    always_comb begin
        state_d        = state_q;
        class_d        = class_q;
        imem_req_raw   = 1'b0;
        ir_write_raw   = 1'b0;
        pc_write_raw   = 1'b0;
        pc_src_raw     = 1'b0;
        mem_to_reg_raw = 1'b0;
        reg_write_raw  = 1'b0;
        mem_read_raw   = 1'b0;
        mem_write_raw  = 1'b0;
        illegal_raw    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req_raw = 1'b1;
                if (imem_ready) begin
                    ir_write_raw = 1'b1;
                    state_d      = ST_DECODE;
                end
            end
            ST_DECODE: begin
                class_d = dec_class;
                state_d = (dec_class == CLS_ILL) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_R:          state_d = ST_WB;
                    CLS_LD, CLS_ST: state_d = ST_MEM;
                    CLS_CBZ: begin
                        pc_write_raw = 1'b1;
                        pc_src_raw   = zero;
                        state_d      = ST_FETCH;
                    end
                    CLS_B: begin
                        pc_write_raw = 1'b1;
                        pc_src_raw   = 1'b1;
                        state_d      = ST_FETCH;
                    end
                    default:        state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                case (class_q)
                    CLS_LD: begin
                        mem_read_raw = 1'b1;
                        if (dmem_ready) begin
                            state_d = ST_WB;
                        end
                    end
                    CLS_ST: begin
                        mem_write_raw = 1'b1;
                        // A store has no writeback, so it retires on the
                        // cycle the data memory accepts it.
                        if (dmem_ready) begin
                            pc_write_raw = 1'b1;
                            state_d      = ST_FETCH;
                        end
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_WB: begin
                reg_write_raw  = 1'b1;
                pc_write_raw   = 1'b1;
                mem_to_reg_raw = (class_q == CLS_LD);
                state_d        = ST_FETCH;
            end
            ST_TRAP: begin
                illegal_raw = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // The class register only updates at the end of DECODE, so during DECODE
    // itself the selects come straight from the decoder.
    assign sel_class = (state_q == ST_DECODE) ? dec_class : class_q;

    // Datapath selects: held from DECODE until the instruction ends, 0 in FETCH/TRAP.
    always_comb begin
        reg2loc_raw = 1'b0;
        alu_src_raw = 1'b0;
        alu_op_raw  = ALUOP_ADD;
        if (state_q != ST_FETCH && state_q != ST_TRAP) begin
            case (sel_class)
                CLS_LD: begin
                    alu_src_raw = 1'b1;
                    alu_op_raw  = ALUOP_ADD;
                end
                CLS_ST: begin
                    alu_src_raw = 1'b1;
                    alu_op_raw  = ALUOP_ADD;
                    reg2loc_raw = 1'b1;
                end
                CLS_CBZ: begin
                    alu_op_raw  = ALUOP_PASSB;
                    reg2loc_raw = 1'b1;
                end
                CLS_R: begin
                    alu_op_raw  = ALUOP_RTYPE;
                end
                default: begin
                    alu_op_raw  = ALUOP_ADD;
                end
            endcase
        end
    end

    // Every output is forced low in a reset cycle, which also suppresses a
    // pc_write from an instruction that is being abandoned.
    assign imem_req   = imem_req_raw   & ~reset;
    assign ir_write   = ir_write_raw   & ~reset;
    assign pc_write   = pc_write_raw   & ~reset;
    assign pc_src     = pc_src_raw     & ~reset;
    assign reg2loc    = reg2loc_raw    & ~reset;
    assign alu_src    = alu_src_raw    & ~reset;
    assign mem_to_reg = mem_to_reg_raw & ~reset;
    assign reg_write  = reg_write_raw  & ~reset;
    assign mem_read   = mem_read_raw   & ~reset;
    assign mem_write  = mem_write_raw  & ~reset;
    assign illegal    = illegal_raw    & ~reset;
    assign alu_op     = reset ? 2'b00 : alu_op_raw;
    assign state      = reset ? 3'd0  : state_q;
    assign retired    = pc_write;

`ifdef MC_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, pc_write_raw};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = reset ? '0 : cycle_cnt_q;
    assign instr_cnt = reset ? '0 : instr_cnt_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed vector bench for multicycle_control (honours MC_CTRL_PERF_CNT_EN)
module tb_multicycle_control;

    localparam int CNT_W = 4;

    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] ORR  = 11'b10101010000;
    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] CBZ  = 11'b10110100101;
    localparam logic [10:0] BR   = 11'b00010100011;
    localparam logic [10:0] ILL  = 11'b11111111111;

    // Field order: state imem_req ir_write pc_write pc_src reg2loc alu_src
    //              mem_to_reg reg_write mem_read mem_write alu_op illegal retired
    localparam logic [16:0] E_ZERO   = 17'b000_0_0_0_0_0_0_0_0_0_0_00_0_0;
    localparam logic [16:0] E_FWAIT  = 17'b000_1_0_0_0_0_0_0_0_0_0_00_0_0;
    localparam logic [16:0] E_FGO    = 17'b000_1_1_0_0_0_0_0_0_0_0_00_0_0;
    localparam logic [16:0] E_R_DEC  = 17'b001_0_0_0_0_0_0_0_0_0_0_10_0_0;
    localparam logic [16:0] E_R_EXE  = 17'b010_0_0_0_0_0_0_0_0_0_0_10_0_0;
    localparam logic [16:0] E_R_WB   = 17'b100_0_0_1_0_0_0_0_1_0_0_10_0_1;
    localparam logic [16:0] E_LD_DEC = 17'b001_0_0_0_0_0_1_0_0_0_0_00_0_0;
    localparam logic [16:0] E_LD_EXE = 17'b010_0_0_0_0_0_1_0_0_0_0_00_0_0;
    localparam logic [16:0] E_LD_MEM = 17'b011_0_0_0_0_0_1_0_0_1_0_00_0_0;
    localparam logic [16:0] E_LD_WB  = 17'b100_0_0_1_0_0_1_1_1_0_0_00_0_1;
    localparam logic [16:0] E_CZ_DEC = 17'b001_0_0_0_0_1_0_0_0_0_0_01_0_0;
    localparam logic [16:0] E_CZ_EX1 = 17'b010_0_0_1_1_1_0_0_0_0_0_01_0_1;
    localparam logic [16:0] E_CZ_EX0 = 17'b010_0_0_1_0_1_0_0_0_0_0_01_0_1;
    localparam logic [16:0] E_B_DEC  = 17'b001_0_0_0_0_0_0_0_0_0_0_00_0_0;
    localparam logic [16:0] E_B_EXE  = 17'b010_0_0_1_1_0_0_0_0_0_0_00_0_1;
    localparam logic [16:0] E_ST_DEC = 17'b001_0_0_0_0_1_1_0_0_0_0_00_0_0;
    localparam logic [16:0] E_ST_EXE = 17'b010_0_0_0_0_1_1_0_0_0_0_00_0_0;
    localparam logic [16:0] E_ST_MW  = 17'b011_0_0_0_0_1_1_0_0_0_1_00_0_0;
    localparam logic [16:0] E_ST_MR  = 17'b011_0_0_1_0_1_1_0_0_0_1_00_0_1;
    localparam logic [16:0] E_IL_DEC = 17'b001_0_0_0_0_0_0_0_0_0_0_00_0_0;
    localparam logic [16:0] E_TRAP   = 17'b111_0_0_0_0_0_0_0_0_0_0_00_1_0;

    typedef struct {
        logic        rst;
        logic [10:0] opc;
        logic        z;
        logic        ir;
        logic        dr;
        logic [16:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset, zero, imem_ready, dmem_ready;
    logic [10:0]      opcode;
    logic             imem_req, ir_write, pc_write, pc_src, reg2loc, alu_src;
    logic             mem_to_reg, reg_write, mem_read, mem_write, illegal, retired;
    logic [1:0]       alu_op;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    multicycle_control #(.OPC_W(11), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .zero      (zero),
        .imem_ready(imem_ready),
        .dmem_ready(dmem_ready),
        .imem_req  (imem_req),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .reg2loc   (reg2loc),
        .alu_src   (alu_src),
        .mem_to_reg(mem_to_reg),
        .reg_write (reg_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .alu_op    (alu_op),
        .state     (state),
        .illegal   (illegal),
        .retired   (retired),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    function automatic logic [16:0] outs();
        return {state, imem_req, ir_write, pc_write, pc_src, reg2loc, alu_src,
                mem_to_reg, reg_write, mem_read, mem_write, alu_op, illegal, retired};
    endfunction

    task automatic add(input logic r, input logic [10:0] o, input logic z,
                       input logic i, input logic d, input logic [16:0] e);
        vec_t v;
        v.rst = r; v.opc = o; v.z = z; v.ir = i; v.dr = d; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [10:0] o, input logic z,
                         input logic i, input logic d);
        reset = r; opcode = o; zero = z; imem_ready = i; dmem_ready = d;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", nm, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = ADD; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;

        // reset
        add(1, ADD, 0, 1, 1, E_ZERO);
        add(1, ADD, 0, 1, 1, E_ZERO);
        // ADD, zero-wait, ready inputs high where they must be ignored
        add(0, ADD, 0, 1, 0, E_FGO);
        add(0, ADD, 0, 1, 1, E_R_DEC);
        add(0, ADD, 0, 1, 1, E_R_EXE);
        add(0, ADD, 0, 1, 1, E_R_WB);
        // LDUR with two data-memory wait cycles: 7 cycles total
        add(0, LDUR, 0, 1, 0, E_FGO);
        add(0, LDUR, 0, 0, 1, E_LD_DEC);
        add(0, LDUR, 0, 0, 1, E_LD_EXE);
        add(0, LDUR, 0, 1, 0, E_LD_MEM);
        add(0, LDUR, 0, 1, 0, E_LD_MEM);
        add(0, LDUR, 0, 0, 1, E_LD_MEM);
        add(0, LDUR, 0, 1, 1, E_LD_WB);
        // CBZ taken, then not taken
        add(0, CBZ, 1, 1, 0, E_FGO);
        add(0, CBZ, 1, 0, 0, E_CZ_DEC);
        add(0, CBZ, 1, 0, 0, E_CZ_EX1);
        add(0, CBZ, 0, 1, 0, E_FGO);
        add(0, CBZ, 0, 0, 0, E_CZ_DEC);
        add(0, CBZ, 0, 0, 0, E_CZ_EX0);
        // unconditional B
        add(0, BR, 0, 1, 0, E_FGO);
        add(0, BR, 0, 0, 0, E_B_DEC);
        add(0, BR, 0, 0, 0, E_B_EXE);
        // STUR: one fetch wait, data memory ready in the MEM entry cycle
        add(0, STUR, 0, 0, 1, E_FWAIT);
        add(0, STUR, 0, 1, 1, E_FGO);
        add(0, STUR, 0, 0, 0, E_ST_DEC);
        add(0, STUR, 0, 0, 0, E_ST_EXE);
        add(0, STUR, 0, 0, 1, E_ST_MR);
        // ORR: opcode changes after DECODE, the latched class must hold
        add(0, ORR, 0, 1, 0, E_FGO);
        add(0, ORR, 0, 0, 0, E_R_DEC);
        add(0, ILL, 0, 0, 0, E_R_EXE);
        add(0, ILL, 0, 0, 0, E_R_WB);
        // illegal opcode: trap held until reset
        add(0, ILL, 0, 1, 0, E_FGO);
        add(0, ILL, 0, 1, 0, E_IL_DEC);
        add(0, ILL, 0, 1, 0, E_TRAP);
        add(0, ILL, 0, 1, 1, E_TRAP);
        add(0, ADD, 0, 1, 1, E_TRAP);
        add(1, ADD, 0, 1, 1, E_ZERO);
        add(0, ADD, 0, 0, 0, E_FWAIT);

        @(posedge clk);
        #1;
        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].opc, vecs[k].z, vecs[k].ir, vecs[k].dr);
            chk($sformatf("vec%0d", k), {15'd0, outs()}, {15'd0, vecs[k].exp});
            adv();
        end

        // Reset during the MEM wait of a STUR
        drive(1, STUR, 0, 1, 0); adv();
        drive(0, STUR, 0, 1, 0); chk("stmid_fetch", {15'd0, outs()}, {15'd0, E_FGO}); adv();
        drive(0, STUR, 0, 0, 0); adv();
        drive(0, STUR, 0, 0, 0); adv();
        drive(0, STUR, 0, 0, 0); chk("stmid_mem", {15'd0, outs()}, {15'd0, E_ST_MW}); adv();
        drive(1, STUR, 0, 0, 1);
        chk("stmid_rst_mw", {31'd0, mem_write}, 32'd0);
        chk("stmid_rst_pcw", {31'd0, pc_write}, 32'd0);
        adv();
        drive(0, STUR, 0, 0, 0); chk("stmid_after", {15'd0, outs()}, {15'd0, E_FWAIT}); adv();

        // Counters over back-to-back zero-wait ADDs
        drive(1, ADD, 0, 1, 1);
        chk("cnt_rst_cyc", {28'd0, cycle_cnt}, 32'd0);
        chk("cnt_rst_ins", {28'd0, instr_cnt}, 32'd0);
        adv();
        for (int n = 0; n <= 64; n++) begin
            drive(0, ADD, 0, 1, 1);
            if (n == 12 || n == 16 || n == 60 || n == 64) begin
`ifdef MC_CTRL_PERF_CNT_EN
                chk($sformatf("cyc_cnt_n%0d", n), {28'd0, cycle_cnt}, n % 16);
                chk($sformatf("ins_cnt_n%0d", n), {28'd0, instr_cnt}, (n / 4) % 16);
`else
                chk($sformatf("cyc_cnt_n%0d", n), {28'd0, cycle_cnt}, 32'd0);
                chk($sformatf("ins_cnt_n%0d", n), {28'd0, instr_cnt}, 32'd0);
`endif
            end
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
